// File: rtl/dmem_byte_bridge_if.sv
// Bus bundle between the CPU data port, the byte bridge and a byte-wide SRAM.
// The master side is the CPU plus the SRAM model; the slave side is the bridge.
interface dmem_byte_bridge_if #(
   parameter int ADDR_W = 32
);
   logic              req_en;
   logic [3:0]        req_wea;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              stall;
   logic [31:0]       rdata;
   logic              rdata_valid;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;

   modport master (
      output req_en, req_wea, req_addr, req_wdata, mem_rdata,
      input  stall, rdata, rdata_valid, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  req_en, req_wea, req_addr, req_wdata, mem_rdata,
      output stall, rdata, rdata_valid, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dmem_byte_bridge.sv
// Splits 32-bit CPU data accesses into byte accesses on an 8-bit SRAM:
// stores touch only enabled lanes, loads fetch all four lanes and reassemble.
module dmem_byte_bridge #(
   parameter int ADDR_W = 32
) (
   input  logic             clk,
   input  logic             resetn,
   dmem_byte_bridge_if.slave bus
);

   typedef enum logic [2:0] {IDLE, WRITE, READ, RWAIT, DONE} state_t;

   state_t            state_r, state_s;
   logic [ADDR_W-3:0] addr_r, addr_s;
   logic [3:0]        wea_r, wea_s;
   logic [31:0]       wdata_r, wdata_s;
   logic [1:0]        lane_r, lane_s;
   logic              is_read_r, is_read_s;
   logic [31:0]       rdata_r, rdata_s;
   logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
   logic [7:0]        mem_wdata_r, mem_wdata_s;
   logic              mem_en_r, mem_en_s;
   logic              mem_we_r, mem_we_s;
   logic              rdata_valid_r, rdata_valid_s;
   logic [2:0]        hit_s;

   // Lowest enabled lane at or above start; bit 2 flags that one was found.
   function automatic logic [2:0] find_lane(input logic [3:0] mask, input logic [2:0] start);
      logic [2:0] res;
      res = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         if (mask[i] && (3'(i) >= start)) res = {1'b1, 2'(i)};
         else                             res = res;
      end
      return res;
   endfunction

   function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] lane);
      logic [7:0] res;
      case (lane)
         2'd0:    res = word[7:0];
         2'd1:    res = word[15:8];
         2'd2:    res = word[23:16];
         2'd3:    res = word[31:24];
         default: res = 8'h00;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] lane,
                                            input logic [7:0] b);
      logic [31:0] res;
      res = word;
      case (lane)
         2'd0:    res[7:0]   = b;
         2'd1:    res[15:8]  = b;
         2'd2:    res[23:16] = b;
         2'd3:    res[31:24] = b;
         default: res        = word;
      endcase
      return res;
   endfunction

   // Next-state and next-output logic; SRAM outputs are registered so they hold between accesses.
   always_comb begin
      state_s       = state_r;
      addr_s        = addr_r;
      wea_s         = wea_r;
      wdata_s       = wdata_r;
      lane_s        = lane_r;
      is_read_s     = is_read_r;
      rdata_s       = rdata_r;
      mem_addr_s    = mem_addr_r;
      mem_wdata_s   = mem_wdata_r;
      mem_en_s      = 1'b0;
      mem_we_s      = 1'b0;
      rdata_valid_s = 1'b0;
      hit_s         = 3'b000;
      case (state_r)
         IDLE: begin
            if (bus.req_en) begin
               addr_s    = bus.req_addr[ADDR_W-1:2];
               wea_s     = bus.req_wea;
               wdata_s   = bus.req_wdata;
               is_read_s = (bus.req_wea == 4'b0000);
               hit_s     = find_lane(bus.req_wea, 3'd0);
               mem_en_s  = 1'b1;
               if (bus.req_wea == 4'b0000) begin
                  state_s    = READ;
                  lane_s     = 2'd0;
                  mem_addr_s = {bus.req_addr[ADDR_W-1:2], 2'd0};
               end else begin
                  state_s     = WRITE;
                  lane_s      = hit_s[1:0];
                  mem_we_s    = 1'b1;
                  mem_addr_s  = {bus.req_addr[ADDR_W-1:2], hit_s[1:0]};
                  mem_wdata_s = byte_sel(bus.req_wdata, hit_s[1:0]);
               end
            end else begin
               state_s = IDLE;
            end
         end
         WRITE: begin
            // Jump straight to the next enabled lane so disabled lanes cost nothing.
            hit_s = find_lane(wea_r, {1'b0, lane_r} + 3'd1);
            if (hit_s[2]) begin
               lane_s      = hit_s[1:0];
               mem_en_s    = 1'b1;
               mem_we_s    = 1'b1;
               mem_addr_s  = {addr_r, hit_s[1:0]};
               mem_wdata_s = byte_sel(wdata_r, hit_s[1:0]);
            end else begin
               state_s = DONE;
            end
         end
         READ: begin
            // SRAM data lags the strobe by one cycle, so this cycle returns lane_r-1.
            if (lane_r != 2'd0) rdata_s = put_byte(rdata_r, lane_r - 2'd1, bus.mem_rdata);
            else                rdata_s = rdata_r;
            if (lane_r == 2'd3) begin
               state_s = RWAIT;
            end else begin
               lane_s     = lane_r + 2'd1;
               mem_en_s   = 1'b1;
               mem_addr_s = {addr_r, lane_r + 2'd1};
            end
         end
         RWAIT: begin
            rdata_s       = put_byte(rdata_r, 2'd3, bus.mem_rdata);
            state_s       = DONE;
            rdata_valid_s = is_read_r;
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r       <= IDLE;
         addr_r        <= '0;
         wea_r         <= 4'b0000;
         wdata_r       <= 32'h0000_0000;
         lane_r        <= 2'd0;
         is_read_r     <= 1'b0;
         rdata_r       <= 32'h0000_0000;
         mem_addr_r    <= '0;
         mem_wdata_r   <= 8'h00;
         mem_en_r      <= 1'b0;
         mem_we_r      <= 1'b0;
         rdata_valid_r <= 1'b0;
      end else begin
         state_r       <= state_s;
         addr_r        <= addr_s;
         wea_r         <= wea_s;
         wdata_r       <= wdata_s;
         lane_r        <= lane_s;
         is_read_r     <= is_read_s;
         rdata_r       <= rdata_s;
         mem_addr_r    <= mem_addr_s;
         mem_wdata_r   <= mem_wdata_s;
         mem_en_r      <= mem_en_s;
         mem_we_r      <= mem_we_s;
         rdata_valid_r <= rdata_valid_s;
      end
   end

   // Stall is combinational so the CPU freezes in the very cycle it presents a request.
   assign bus.stall = ((state_r == IDLE) && bus.req_en) || (state_r == WRITE) ||
                      (state_r == READ) || (state_r == RWAIT);
   assign bus.rdata       = rdata_r;
   assign bus.rdata_valid = rdata_valid_r;
   assign bus.mem_en      = mem_en_r;
   assign bus.mem_we      = mem_we_r;
   assign bus.mem_addr    = mem_addr_r;
   assign bus.mem_wdata   = mem_wdata_r;

endmodule

// File: tb/tb_dmem_byte_bridge.sv
// Directed bench for dmem_byte_bridge: byte-lane stores, word loads, mid-access
// reset and back-to-back loads against a small byte-SRAM model.
module tb_dmem_byte_bridge;

   logic clk = 1'b0;
   logic resetn;
   int   tests = 0;
   int   fails = 0;
   logic [7:0] mem [0:1023];

   dmem_byte_bridge_if #(.ADDR_W(32)) bus ();

   dmem_byte_bridge #(.ADDR_W(32)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Byte SRAM: read data appears the cycle after the strobe.
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
         else            bus.mem_rdata <= mem[bus.mem_addr[9:0]];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Garbage request held after capture; it must be ignored until IDLE.
   task automatic scramble();
      bus.req_en    = 1'b1;
      bus.req_wea   = 4'hF;
      bus.req_addr  = 32'hFFFF_FFFC;
      bus.req_wdata = 32'h5555_5555;
   endtask

   task automatic clear_req();
      bus.req_en    = 1'b0;
      bus.req_wea   = 4'h0;
      bus.req_addr  = 32'h0;
      bus.req_wdata = 32'h0;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                           input int n, input logic [127:0] ea, input logic [31:0] ed);
      bus.req_en = 1'b1; bus.req_wea = we; bus.req_addr = a; bus.req_wdata = wd;
      #1;
      chk("w_stall_capture", bus.stall, 1);
      for (int i = 0; i < n; i++) begin
         cyc();
         if (i == 0) scramble();
         #1;
         chk("w_mem_en", bus.mem_en, 1);
         chk("w_mem_we", bus.mem_we, 1);
         chk("w_mem_addr", bus.mem_addr, ea[32*i +: 32]);
         chk("w_mem_wdata", bus.mem_wdata, ed[8*i +: 8]);
         chk("w_stall", bus.stall, 1);
         chk("w_rdata_valid", bus.rdata_valid, 0);
      end
      cyc();
      chk("w_done_mem_en", bus.mem_en, 0);
      chk("w_done_mem_we", bus.mem_we, 0);
      chk("w_done_stall", bus.stall, 0);
      chk("w_done_valid", bus.rdata_valid, 0);
      chk("w_done_addr_hold", bus.mem_addr, ea[32*(n-1) +: 32]);
      chk("w_done_wdata_hold", bus.mem_wdata, ed[8*(n-1) +: 8]);
      cyc();
      clear_req();
      #1;
      chk("w_idle_mem_en", bus.mem_en, 0);
      chk("w_idle_stall", bus.stall, 0);
   endtask

   task automatic do_read(input logic [31:0] a, input logic [31:0] w, input logic [31:0] prev);
      logic [31:0] m;
      bus.req_en = 1'b1; bus.req_wea = 4'h0; bus.req_addr = a; bus.req_wdata = 32'h0;
      #1;
      chk("r_stall_capture", bus.stall, 1);
      chk("r_rdata_capture", bus.rdata, prev);
      for (int k = 0; k < 4; k++) begin
         cyc();
         if (k == 0) scramble();
         #1;
         m = (k == 2) ? 32'h0000_00FF : (k == 3) ? 32'h0000_FFFF : 32'h0;
         chk("r_mem_en", bus.mem_en, 1);
         chk("r_mem_we", bus.mem_we, 0);
         chk("r_mem_addr", bus.mem_addr, (a & 32'hFFFF_FFFC) + 32'(k));
         chk("r_stall", bus.stall, 1);
         chk("r_valid_early", bus.rdata_valid, 0);
         chk("r_rdata_partial", bus.rdata, (prev & ~m) | (w & m));
      end
      cyc();
      chk("r_rwait_mem_en", bus.mem_en, 0);
      chk("r_rwait_stall", bus.stall, 1);
      chk("r_rwait_valid", bus.rdata_valid, 0);
      chk("r_rwait_rdata", bus.rdata, (prev & 32'hFF00_0000) | (w & 32'h00FF_FFFF));
      cyc();
      chk("r_done_valid", bus.rdata_valid, 1);
      chk("r_done_rdata", bus.rdata, w);
      chk("r_done_stall", bus.stall, 0);
      chk("r_done_mem_en", bus.mem_en, 0);
      cyc();
      clear_req();
      #1;
      chk("r_idle_mem_en", bus.mem_en, 0);
      chk("r_idle_valid", bus.rdata_valid, 0);
      chk("r_idle_rdata_hold", bus.rdata, w);
   endtask

   initial begin
      clear_req();
      resetn = 1'b1;
      #1;
      resetn = 1'b0;
      #1;
      chk("rst_stall", bus.stall, 0);
      chk("rst_mem_en", bus.mem_en, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_valid", bus.rdata_valid, 0);
      chk("rst_rdata", bus.rdata, 32'h0);
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
      chk("rst_mem_wdata", bus.mem_wdata, 8'h00);
      bus.req_en = 1'b1;
      #1;
      chk("rst_stall_follows_req", bus.stall, 1);
      bus.req_en = 1'b0;
      cyc();
      cyc();
      resetn = 1'b1;

      // Full-word store, then byte, upper and lower halfword stores.
      do_write(32'h100, 4'hF, 32'hDEAD_BEEF, 4,
               {32'h103, 32'h102, 32'h101, 32'h100}, 32'hDEAD_BEEF);
      do_write(32'h202, 4'b0100, 32'h00AB_0000, 1, {96'h0, 32'h202}, 32'h0000_00AB);
      do_write(32'h204, 4'b1100, 32'h1234_0000, 2, {64'h0, 32'h207, 32'h206}, 32'h0000_1234);
      do_write(32'h204, 4'b0011, 32'h0000_5678, 2, {64'h0, 32'h205, 32'h204}, 32'h0000_5678);

      // Word load of the first store; rdata untouched by the stores.
      do_read(32'h100, 32'hDEAD_BEEF, 32'h0);

      // Reset while lane 2 of a load is on the bus.
      bus.req_en = 1'b1; bus.req_wea = 4'h0; bus.req_addr = 32'h100;
      cyc();
      clear_req();
      cyc();
      cyc();
      chk("mid_lane2_en", bus.mem_en, 1);
      chk("mid_lane2_addr", bus.mem_addr, 32'h102);
      resetn = 1'b0;
      #1;
      chk("mid_rst_mem_en", bus.mem_en, 0);
      chk("mid_rst_mem_we", bus.mem_we, 0);
      chk("mid_rst_stall", bus.stall, 0);
      chk("mid_rst_valid", bus.rdata_valid, 0);
      chk("mid_rst_rdata", bus.rdata, 32'h0);
      chk("mid_rst_mem_addr", bus.mem_addr, 32'h0);
      cyc();
      chk("mid_rst_hold_en", bus.mem_en, 0);
      resetn = 1'b1;

      // Load right after reset, then a second load with no idle gap.
      do_read(32'h100, 32'hDEAD_BEEF, 32'h0);
      do_read(32'h206, 32'h1234_5678, 32'hDEAD_BEEF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dmem_byte_bridge.md
DMEM_BYTE_BRIDGE -- requirements
Module: dmem_byte_bridge

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, giving the byte-address width on both sides.
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port resetn, input, 1: reset, asynchronous and active-low.
REQ-004 The block SHALL have port req_en, input, 1: CPU data-memory request valid.
REQ-005 The block SHALL have port req_wea, input, 4: per-byte-lane write enables; 4'b0000 with req_en means a word read.
REQ-006 The block SHALL have port req_addr, input, ADDR_W: CPU byte address; bits [1:0] are ignored, since lanes come from req_wea.
REQ-007 The block SHALL have port req_wdata, input, 32: lane-aligned store data, lane k = bits [8k+7:8k].
REQ-008 The block SHALL have port stall, output, 1: CPU must hold the request and freeze its pipeline while high.
REQ-009 The block SHALL have port rdata, output, 32: assembled read word, little-endian lane order.
REQ-010 The block SHALL have port rdata_valid, output, 1: one-cycle pulse marking rdata complete.
REQ-011 The block SHALL have port mem_en, output, 1: byte-SRAM access strobe.
REQ-012 The block SHALL have port mem_we, output, 1: byte-SRAM write strobe, qualified by mem_en.
REQ-013 The block SHALL have port mem_addr, output, ADDR_W: byte-SRAM address, equal to {captured addr[ADDR_W-1:2], lane[1:0]}.
REQ-014 The block SHALL have port mem_wdata, output, 8: byte-SRAM write data.
REQ-015 The block SHALL have port mem_rdata, input, 8: byte-SRAM read data, valid exactly one cycle after a read strobe.

Function
REQ-016 The block SHALL implement an FSM with states IDLE, WRITE, READ, RWAIT and DONE.
REQ-017 In IDLE with req_en=1, the block SHALL capture req_addr, req_wea and req_wdata, then go to WRITE if req_wea!=0 and to READ otherwise.
REQ-018 The stall output SHALL equal (IDLE & req_en) | WRITE | READ | RWAIT, so it is combinationally high in the capture cycle and low in DONE.
REQ-019 In WRITE, the block SHALL visit enabled lanes in ascending order, one lane per cycle, driving mem_en=1, mem_we=1, mem_addr lane = k and mem_wdata = captured byte k.
REQ-020 In WRITE, disabled lanes SHALL be skipped at zero cycle cost.
REQ-021 After the last enabled lane, the block SHALL go to DONE, so a write takes popcount(req_wea) cycles in WRITE.
REQ-022 In READ, the block SHALL issue byte reads to lanes 0,1,2,3 on four consecutive cycles with mem_en=1 and mem_we=0, then go to RWAIT.
REQ-023 The block SHALL latch mem_rdata into rdata[8k+7:8k] in the cycle after the read strobe for lane k; the lane-3 byte is latched in RWAIT.
REQ-024 RWAIT SHALL go to DONE after one cycle.
REQ-025 In DONE, the block SHALL pulse rdata_valid=1 if and only if the operation was a read.
REQ-026 DONE SHALL always go to IDLE after one cycle, and req_en SHALL be ignored in DONE.
REQ-027 Read timing: with capture at cycle N, strobes SHALL occur at N+1..N+4, RWAIT at N+5, DONE with rdata_valid at N+6, and stall SHALL be high for N..N+5.
REQ-028 Write timing: with capture at cycle N and L enabled lanes, strobes SHALL occur at N+1..N+L, DONE at N+L+1, and stall SHALL be high for N..N+L.
REQ-029 rdata SHALL hold its value until the next read overwrites it; a write SHALL NOT modify rdata.
REQ-030 Outside WRITE and READ, mem_en and mem_we SHALL be 0 and mem_addr and mem_wdata SHALL hold their last values.
REQ-031 Changes on the req_* inputs after the capture cycle SHALL have no effect until the block returns to IDLE.

Reset
REQ-032 When resetn=0, the block SHALL immediately enter IDLE, regardless of clk.
REQ-033 During reset, stall SHALL follow REQ-018 (i.e. equal req_en), and mem_en, mem_we and rdata_valid SHALL be 0.
REQ-034 During reset, rdata, mem_addr and mem_wdata SHALL be 0, and the internal lane counter and captured registers SHALL be cleared.
REQ-035 A reset asserted mid-operation SHALL abort the access with no further strobes issued.
REQ-036 The block SHALL accept a new request in the first cycle after resetn deasserts.

Verification
REQ-037 Full-word store, req_wea=4'hF, addr=0x100, wdata=0xDEADBEEF -> writes at 0x100..0x103 of EF,BE,AD,DE on 4 consecutive cycles, stall high 5 cycles, rdata_valid never pulses.
REQ-038 Byte store, req_wea=4'b0100, addr=0x202, wdata=0x00AB0000 -> exactly one strobe, addr 0x202, data 0xAB, DONE at N+2.
REQ-039 Halfword store, req_wea=4'b1100 -> strobes at lanes 2,3 on N+1 and N+2 only.
REQ-040 Word read at 0x100 after the REQ-037 store -> rdata=0xDEADBEEF with rdata_valid at N+6, stall high N..N+5.
REQ-041 resetn pulsed low at READ lane 2 -> mem_en drops to 0 immediately, rdata=0; a following read completes normally.
REQ-042 Back-to-back requests: second read presented the cycle after DONE -> captured in IDLE with no lost cycle, and rdata of the first read stays stable until the second read's lane 0 capture.
